// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare direction predictor: counter encoding,
// default geometry and the saturating counter update.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_HIST_BITS  = 6;
    localparam int DEF_PC_WIDTH   = 13;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] next;
        next = cnt;
        if (taken && cnt != ST)
            next = cnt + 2'd1;
        else if (!taken && cnt != SNT)
            next = cnt - 2'd1;
        return next;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side lookup and resolve-side training signals of the gshare predictor.
interface gshare_predictor_if
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int HIST_BITS  = DEF_HIST_BITS,
    parameter int PC_WIDTH   = DEF_PC_WIDTH
);
    logic [PC_WIDTH-1:0]   IF_pc;
    logic                  IF_valid;
    logic                  btb_hit;
    logic                  btb_branch;
    logic                  predict_taken;
    logic [INDEX_BITS-1:0] pred_index;
    logic [HIST_BITS-1:0]  pred_ghr;
    logic                  EX_valid;
    logic [INDEX_BITS-1:0] EX_index;
    logic [HIST_BITS-1:0]  EX_ghr;
    logic                  EX_taken;
    logic                  EX_mispredict;

    modport master (
        output IF_pc, IF_valid, btb_hit, btb_branch,
               EX_valid, EX_index, EX_ghr, EX_taken, EX_mispredict,
        input  predict_taken, pred_index, pred_ghr
    );

    modport slave (
        input  IF_pc, IF_valid, btb_hit, btb_branch,
               EX_valid, EX_index, EX_ghr, EX_taken, EX_mispredict,
        output predict_taken, pred_index, pred_ghr
    );
endinterface

// File: rtl/gshare_predictor_pht.sv
// Pattern history table: 2-bit saturating counters with one combinational
// read port and one read-modify-write training port (no read bypass).
module bp_pht
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [1:0]            rd_cnt,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_taken
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0] cnt_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= WNT;
        end else if (wr_en) begin
            cnt_q[wr_index] <= sat_update(cnt_q[wr_index], wr_taken);
        end
    end

    assign rd_cnt = cnt_q[rd_index];

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: hashes fetch PC with the speculative global
// history, predicts from the PHT and repairs history on a mispredict.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int HIST_BITS  = DEF_HIST_BITS,
    parameter int PC_WIDTH   = DEF_PC_WIDTH
) (
    input logic          clk,
    input logic          rst,
    gshare_predictor_if.slave bus
);
    logic [HIST_BITS-1:0]  ghr;
    logic [HIST_BITS-1:0]  ghr_next;
    logic [INDEX_BITS-1:0] idx;
    logic [1:0]            cnt;
    logic [PC_WIDTH-1:0]   pc;
    logic                  unused_bits;

    assign pc          = bus.IF_pc;
    assign unused_bits = &{1'b0, pc[PC_WIDTH-1:INDEX_BITS], cnt[0]};
    assign idx         = pc[INDEX_BITS-1:0] ^ INDEX_BITS'(ghr);

    bp_pht #(.INDEX_BITS(INDEX_BITS)) pht_i (
        .clk      (clk),
        .rst      (rst),
        .rd_index (idx),
        .rd_cnt   (cnt),
        .wr_en    (bus.EX_valid),
        .wr_index (bus.EX_index),
        .wr_taken (bus.EX_taken)
    );

    assign bus.predict_taken = bus.btb_hit & (~bus.btb_branch | cnt[1]);
    assign bus.pred_index    = idx;
    assign bus.pred_ghr      = ghr;

    // The truncating cast drops the oldest bit, which also covers HIST_BITS = 1.
    always_comb begin
        ghr_next = ghr;
        if (bus.EX_valid && bus.EX_mispredict)
            ghr_next = HIST_BITS'({bus.EX_ghr, bus.EX_taken});
        else if (bus.IF_valid && bus.btb_hit && bus.btb_branch)
            ghr_next = HIST_BITS'({ghr, cnt[1]});
    end

    always_ff @(posedge clk) begin
        if (rst)
            ghr <= '0;
        else
            ghr <= ghr_next;
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: a table/history model is checked on
// every falling edge, plus literal expectations at key points.
module tb_gshare_predictor;
    localparam int IB = 6;
    localparam int HB = 6;
    localparam int PW = 13;
    localparam int NENT = 1 << IB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    int m_pht [NENT];
    int m_ghr = 0;

    gshare_predictor_if #(.INDEX_BITS(IB), .HIST_BITS(HB), .PC_WIDTH(PW)) bus ();

    gshare_predictor #(.INDEX_BITS(IB), .HIST_BITS(HB), .PC_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: table of counters 0..3 and an integer history.
    always @(posedge clk) begin
        int idx;
        int pbit;
        if (rst) begin
            for (int i = 0; i < NENT; i++) m_pht[i] <= 1;
            m_ghr <= 0;
        end else begin
            idx  = (int'(bus.IF_pc) % NENT) ^ m_ghr;
            pbit = (m_pht[idx] >= 2) ? 1 : 0;
            if (bus.EX_valid) begin
                if (bus.EX_taken)
                    m_pht[bus.EX_index] <= (m_pht[bus.EX_index] == 3) ? 3 : m_pht[bus.EX_index] + 1;
                else
                    m_pht[bus.EX_index] <= (m_pht[bus.EX_index] == 0) ? 0 : m_pht[bus.EX_index] - 1;
            end
            if (bus.EX_valid && bus.EX_mispredict)
                m_ghr <= (int'(bus.EX_ghr) * 2 + int'(bus.EX_taken)) % (1 << HB);
            else if (bus.IF_valid && bus.btb_hit && bus.btb_branch)
                m_ghr <= (m_ghr * 2 + pbit) % (1 << HB);
        end
    end

    // Per-cycle comparison of the combinational outputs against the model.
    always @(negedge clk) begin
        int idx;
        int exp_taken;
        if (!rst) begin
            idx = (int'(bus.IF_pc) % NENT) ^ m_ghr;
            exp_taken = (bus.btb_hit && (!bus.btb_branch || m_pht[idx] >= 2)) ? 1 : 0;
            check("model_taken", int'(bus.predict_taken), exp_taken);
            check("model_index", int'(bus.pred_index), idx);
            check("model_ghr",   int'(bus.pred_ghr), m_ghr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input int pc, input bit valid, input bit hit, input bit branch);
        bus.IF_pc      = PW'(pc);
        bus.IF_valid   = valid;
        bus.btb_hit    = hit;
        bus.btb_branch = branch;
    endtask

    task automatic set_ex(input bit valid, input int index, input int ghr, input bit taken, input bit mis);
        bus.EX_valid      = valid;
        bus.EX_index      = IB'(index);
        bus.EX_ghr        = HB'(ghr);
        bus.EX_taken      = taken;
        bus.EX_mispredict = mis;
    endtask

    task automatic train(input int index, input bit taken, input int n);
        for (int k = 0; k < n; k++) begin
            set_ex(1'b1, index, 0, taken, 1'b0);
            tick();
        end
        set_ex(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        set_fetch(0, 1'b0, 1'b0, 1'b0);
        set_ex(1'b0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        set_fetch('h010, 1'b0, 1'b1, 1'b1);
        #1;
        check("reset_taken", int'(bus.predict_taken), 0);
        check("reset_index", int'(bus.pred_index), 'h10);
        check("reset_ghr",   int'(bus.pred_ghr), 0);

        // Saturate up, then down
        train('h10, 1'b1, 3);
        check("sat_up_taken", int'(bus.predict_taken), 1);
        check("sat_up_model", m_pht['h10], 3);
        train('h10, 1'b0, 4);
        check("sat_dn_taken", int'(bus.predict_taken), 0);
        check("sat_dn_model", m_pht['h10], 0);

        // Speculative history shift, then stall
        train('h10, 1'b1, 3);
        set_fetch('h010, 1'b1, 1'b1, 1'b1);
        #1;
        check("spec_pre_taken", int'(bus.predict_taken), 1);
        tick();
        set_fetch('h010, 1'b0, 1'b1, 1'b1);
        #1;
        check("spec_ghr",       int'(bus.pred_ghr), 1);
        check("spec_index",     int'(bus.pred_index), 'h11);
        check("spec_model_ghr", m_ghr, 1);
        tick();
        check("stall_ghr", int'(bus.pred_ghr), 1);

        // Recovery wins over a same-cycle speculative shift
        set_fetch('h010, 1'b1, 1'b1, 1'b1);
        set_ex(1'b1, 'h05, 'h2A, 1'b0, 1'b1);
        tick();
        set_fetch('h010, 1'b0, 1'b1, 1'b1);
        set_ex(1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        check("recover_ghr",       int'(bus.pred_ghr), 'h14);
        check("recover_model_ghr", m_ghr, 'h14);

        // Same-cycle read/write collision: no bypass
        train('h10, 1'b0, 2);
        set_fetch('h004, 1'b0, 1'b1, 1'b1);
        set_ex(1'b1, 'h10, 0, 1'b1, 1'b0);
        #1;
        check("collide_index",  int'(bus.pred_index), 'h10);
        check("collide_n_taken", int'(bus.predict_taken), 0);
        tick();
        set_ex(1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        check("collide_n1_taken", int'(bus.predict_taken), 1);

        // Jump then BTB miss: history untouched
        set_fetch('h004, 1'b1, 1'b1, 1'b0);
        #1;
        check("jump_taken", int'(bus.predict_taken), 1);
        tick();
        check("jump_ghr", int'(bus.pred_ghr), 'h14);
        set_fetch('h004, 1'b1, 1'b0, 1'b1);
        #1;
        check("miss_taken", int'(bus.predict_taken), 0);
        tick();
        check("miss_ghr", int'(bus.pred_ghr), 'h14);

        // Reset mid-operation overrides concurrent IF and EX updates
        set_fetch('h010, 1'b1, 1'b1, 1'b1);
        set_ex(1'b1, 'h10, 'h3F, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_fetch('h010, 1'b0, 1'b1, 1'b1);
        set_ex(1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        check("rst2_ghr",   int'(bus.pred_ghr), 0);
        check("rst2_taken", int'(bus.predict_taken), 0);
        train('h10, 1'b1, 1);
        check("rst2_wt_taken", int'(bus.predict_taken), 1);
        train('h10, 1'b0, 1);
        check("rst2_wnt_taken", int'(bus.predict_taken), 0);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
